// File: rtl/spike_rate_accum_if.sv
// spike_rate_accum_if: spike-vector input stream and per-channel count drain stream.
// master = producer/consumer side (testbench or upstream/downstream glue),
// slave  = the accumulator itself.
interface spike_rate_accum_if #(
    parameter int CH = 16,
    parameter int CW = 5,
    parameter int IW = 4
);
    logic [CH-1:0] data_in;
    logic          data_in_valid;
    logic [CW-1:0] count_out;
    logic [IW-1:0] count_idx;
    logic          count_valid;
    logic          count_ready;

    modport master (
        output data_in, data_in_valid, count_ready,
        input  count_out, count_idx, count_valid
    );

    modport slave (
        input  data_in, data_in_valid, count_ready,
        output count_out, count_idx, count_valid
    );
endinterface

// File: rtl/spike_rate_accum.sv
// spike_rate_accum: counts spikes per channel over a T-step frame, then drains
// the CH counts one per valid/ready beat, pulses done and re-arms.
// Optional feature macro: SPIKE_RATE_ARGMAX_EN adds argmax_idx/argmax_cnt,
// a running maximum over the drained counts (ties keep the lower index).
//
// state | meaning
// ACCUM | counting spike beats until T steps are seen
// DRAIN | presenting cnt[idx] on the count stream
// FIN   | one-cycle done pulse, counters cleared for the next frame
module spike_rate_accum #(
    parameter int CH = 16,
    parameter int T  = 30,
    parameter int CW = 5,
    parameter int IW = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    spike_rate_accum_if.slave  bus,
    output logic               overrun,
    output logic               done
`ifdef SPIKE_RATE_ARGMAX_EN
    ,
    output logic [IW-1:0]      argmax_idx,
    output logic [CW-1:0]      argmax_cnt
`endif
);

    typedef enum logic [1:0] {ACCUM, DRAIN, FIN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q [CH];
    logic [CW-1:0] cnt_d [CH];
    logic [CW-1:0] step_q, step_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          overrun_q, overrun_d;

    // Next-state and datapath update; clear pre-empts everything, including a same-cycle beat.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        step_d    = step_q;
        idx_d     = idx_q;
        overrun_d = overrun_q;
        if (clear) begin
            state_d   = ACCUM;
            for (int i = 0; i < CH; i++) cnt_d[i] = '0;
            step_d    = '0;
            idx_d     = '0;
            overrun_d = 1'b0;
        end else begin
            if (bus.data_in_valid && (state_q != ACCUM)) overrun_d = 1'b1;
            case (state_q)
                ACCUM: begin
                    if (bus.data_in_valid) begin
                        for (int i = 0; i < CH; i++)
                            cnt_d[i] = cnt_q[i] + CW'(bus.data_in[i]);
                        step_d = step_q + CW'(1);
                        if (step_q == CW'(T - 1)) begin
                            state_d = DRAIN;
                            idx_d   = '0;
                        end
                    end
                end
                DRAIN: begin
                    if (bus.count_ready) begin
                        idx_d = idx_q + IW'(1);
                        if (idx_q == IW'(CH - 1)) state_d = FIN;
                    end
                end
                FIN: begin
                    for (int i = 0; i < CH; i++) cnt_d[i] = '0;
                    step_d  = '0;
                    idx_d   = '0;
                    state_d = ACCUM;
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    // State, counters and sticky overrun flop bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ACCUM;
            for (int i = 0; i < CH; i++) cnt_q[i] <= '0;
            step_q    <= '0;
            idx_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            step_q    <= step_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
        end
    end

    // Outputs decode purely from registered state, so no input reaches an output combinationally.
    assign bus.count_valid = (state_q == DRAIN);
    assign bus.count_out   = cnt_q[idx_q];
    assign bus.count_idx   = idx_q;
    assign overrun         = overrun_q;
    assign done            = (state_q == FIN);

`ifdef SPIKE_RATE_ARGMAX_EN
    logic [IW-1:0] run_idx_q, run_idx_d;
    logic [CW-1:0] run_cnt_q, run_cnt_d;
    logic [IW-1:0] amx_idx_q, amx_idx_d;
    logic [CW-1:0] amx_cnt_q, amx_cnt_d;
    logic [IW-1:0] cand_idx;
    logic [CW-1:0] cand_cnt;

    // Running max over transferring counts; strict > keeps the earlier (lower) index on ties.
    always_comb begin
        cand_idx  = run_idx_q;
        cand_cnt  = run_cnt_q;
        if ((idx_q == '0) || (cnt_q[idx_q] > run_cnt_q)) begin
            cand_idx = idx_q;
            cand_cnt = cnt_q[idx_q];
        end
        run_idx_d = run_idx_q;
        run_cnt_d = run_cnt_q;
        amx_idx_d = amx_idx_q;
        amx_cnt_d = amx_cnt_q;
        if (clear) begin
            run_idx_d = '0;
            run_cnt_d = '0;
            amx_idx_d = '0;
            amx_cnt_d = '0;
        end else if ((state_q == DRAIN) && bus.count_ready) begin
            run_idx_d = cand_idx;
            run_cnt_d = cand_cnt;
            if (idx_q == IW'(CH - 1)) begin
                amx_idx_d = cand_idx;
                amx_cnt_d = cand_cnt;
            end
        end
    end

    // Argmax flop bank; published result updates only on the last transfer of a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_idx_q <= '0;
            run_cnt_q <= '0;
            amx_idx_q <= '0;
            amx_cnt_q <= '0;
        end else begin
            run_idx_q <= run_idx_d;
            run_cnt_q <= run_cnt_d;
            amx_idx_q <= amx_idx_d;
            amx_cnt_q <= amx_cnt_d;
        end
    end

    assign argmax_idx = amx_idx_q;
    assign argmax_cnt = amx_cnt_q;
`endif

endmodule

// File: tb/tb_spike_rate_accum.sv
// Directed bench for spike_rate_accum: full-frame drains, stalled drain,
// overrun stickiness, clear mid-frame and async reset mid-drain; argmax
// checks are compiled only when SPIKE_RATE_ARGMAX_EN is defined.
module tb_spike_rate_accum;

    logic clk;
    logic rst_n;
    logic clear;
    logic overrun;
    logic done;
`ifdef SPIKE_RATE_ARGMAX_EN
    logic [3:0] argmax_idx;
    logic [4:0] argmax_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    logic [4:0] exp_cnt [16];

    spike_rate_accum_if #(.CH(16), .CW(5), .IW(4)) bus ();

    spike_rate_accum #(.CH(16), .T(30), .CW(5), .IW(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .bus        (bus.slave),
        .overrun    (overrun),
        .done       (done)
`ifdef SPIKE_RATE_ARGMAX_EN
        ,
        .argmax_idx (argmax_idx),
        .argmax_cnt (argmax_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] d);
        bus.data_in       = d;
        bus.data_in_valid = 1'b1;
        tick();
        bus.data_in_valid = 1'b0;
    endtask

    task automatic set_exp(input logic [4:0] v);
        for (int i = 0; i < 16; i++) exp_cnt[i] = v;
    endtask

    // Drains all 16 counts; stall=1 drives ready 1,0,0,1,0,0,...
    task automatic drain(input bit stall);
        int k;
        int c;
        k = 0;
        c = 0;
        while (k < 16 && c < 100) begin
            bus.count_ready = stall ? (c % 3 == 0) : 1'b1;
            chk("drain_valid", bus.count_valid, 1);
            chk("drain_idx", bus.count_idx, k);
            chk("drain_cnt", bus.count_out, exp_cnt[k]);
            chk("drain_no_done", done, 0);
            tick();
            if (bus.count_ready) k++;
            c++;
        end
        chk("drain_xfers", k, 16);
        chk("drain_cycles", c, stall ? 46 : 16);
        chk("done_pulse", done, 1);
        chk("fin_valid_low", bus.count_valid, 0);
        tick();
        chk("done_low", done, 0);
    endtask

    initial begin
        rst_n             = 1'b0;
        clear             = 1'b0;
        bus.data_in       = '0;
        bus.data_in_valid = 1'b0;
        bus.count_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count_out", bus.count_out, 0);
        chk("rst_count_idx", bus.count_idx, 0);
        chk("rst_count_valid", bus.count_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_done", done, 0);
`ifdef SPIKE_RATE_ARGMAX_EN
        chk("rst_argmax_idx", argmax_idx, 0);
        chk("rst_argmax_cnt", argmax_cnt, 0);
`endif
        rst_n = 1'b1;
        tick();

        // Frame 1: all channels spike every step.
        bus.count_ready = 1'b1;
        for (int i = 0; i < 29; i++) beat(16'hFFFF);
        chk("accum_valid_low", bus.count_valid, 0);
        beat(16'hFFFF);
        chk("valid_after_T", bus.count_valid, 1);
        set_exp(5'd30);
        drain(1'b0);
        chk("f1_overrun", overrun, 0);

        // Frame 2: alternating halves, 15 each; starts the cycle right after FIN.
        for (int i = 0; i < 30; i++) beat((i % 2 == 0) ? 16'hAAAA : 16'h5555);
        set_exp(5'd15);
        drain(1'b0);

        // Frame 3: 10 x 00FF then 20 x FF00, drained with backpressure.
        for (int i = 0; i < 10; i++) beat(16'h00FF);
        for (int i = 0; i < 20; i++) beat(16'hFF00);
        for (int i = 0; i < 16; i++) exp_cnt[i] = (i < 8) ? 5'd10 : 5'd20;
        drain(1'b1);

        // Frame 4: overrun during DRAIN leaves counts untouched and sticks until clear.
        for (int i = 0; i < 30; i++) beat(16'h0003);
        bus.count_ready = 1'b0;
        beat(16'hFFFF);
        chk("overrun_set", overrun, 1);
        chk("overrun_idx_hold", bus.count_idx, 0);
        chk("overrun_cnt_hold", bus.count_out, 30);
        set_exp(5'd0);
        exp_cnt[0] = 5'd30;
        exp_cnt[1] = 5'd30;
        drain(1'b0);
        chk("overrun_sticky", overrun, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("overrun_cleared", overrun, 0);

        // Frame 5: clear after 12 beats (same-cycle beat discarded), then 30 x 0001.
        for (int i = 0; i < 12; i++) beat(16'hFFFF);
        bus.data_in       = 16'hFFFF;
        bus.data_in_valid = 1'b1;
        clear             = 1'b1;
        tick();
        clear             = 1'b0;
        bus.data_in_valid = 1'b0;
        chk("clear_valid", bus.count_valid, 0);
        chk("clear_cnt0", bus.count_out, 0);
        chk("clear_overrun", overrun, 0);
        for (int i = 0; i < 29; i++) beat(16'h0001);
        chk("clr_accum_valid_low", bus.count_valid, 0);
        beat(16'h0001);
        bus.count_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("f5_valid", bus.count_valid, 1);
            chk("f5_idx", bus.count_idx, k);
            chk("f5_cnt", bus.count_out, (k == 0) ? 30 : 0);
            tick();
        end
        // Async reset in the middle of a cycle, no clock edge involved.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", bus.count_valid, 0);
        chk("async_rst_idx", bus.count_idx, 0);
        chk("async_rst_cnt", bus.count_out, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_overrun", overrun, 0);
        tick();
        rst_n = 1'b1;
        tick();

`ifdef SPIKE_RATE_ARGMAX_EN
        // ch3/ch9 reach 20 (tie -> lower index 3), ch5 19, ch0 10.
        for (int i = 0; i < 20; i++) beat((i < 19) ? 16'h0228 : 16'h0208);
        for (int i = 0; i < 10; i++) beat(16'h0001);
        set_exp(5'd0);
        exp_cnt[0] = 5'd10;
        exp_cnt[3] = 5'd20;
        exp_cnt[5] = 5'd19;
        exp_cnt[9] = 5'd20;
        drain(1'b0);
        chk("argmax_idx", argmax_idx, 3);
        chk("argmax_cnt", argmax_cnt, 20);
        beat(16'hFFFF);
        chk("argmax_idx_held", argmax_idx, 3);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("argmax_idx_clear", argmax_idx, 0);
        chk("argmax_cnt_clear", argmax_cnt, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/spike_rate_accum.md
# spike_rate_accum

- Rate-decoding stage directly downstream of `layer_norm_2`.
- Consumes its 16-channel binary spike vectors, one per time step, and counts spikes per channel over a T=30-step frame.
- Once the frame is complete, drains the 16 counts one per beat over a valid/ready handshake, then pulses `done` and re-arms for the next frame.

## Interface
- `CH`, 16: spike channels per input beat.
- `T`, 30: time steps per frame.
- `CW`, 5: counter width, must satisfy 2^CW > T.
- `IW`, 4: channel index width, must satisfy 2^IW >= CH.
- `clk`  in  1: single clock; all logic on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `data_in`  in  CH: spike vector from `layer_norm_2`; bit i is the spike for channel i.
- `data_in_valid`  in  1: `data_in` holds one time step this cycle.
- `clear`  in  1: synchronous frame abort; highest priority after reset.
- `count_out`  out  CW: spike count for channel `count_idx`.
- `count_idx`  out  IW: channel index of the presented count.
- `count_valid`  out  1: `count_out`/`count_idx` are valid.
- `count_ready`  in  1: consumer accepts the presented count.
- `overrun`  out  1: sticky; a beat arrived while not accumulating.
- `done`  out  1: one-cycle pulse after the last count transfers.

## Operation
- States: `ACCUM`, `DRAIN`, `FIN`. Reset enters `ACCUM` with all counters, step count and index zero.
- **ACCUM**
  - Each `data_in_valid` cycle: `cnt[i] <= cnt[i] + data_in[i]` for every i, and `step <= step + 1`.
  - The beat that makes step == T moves the FSM to `DRAIN` with `idx = 0`.
  - No saturation logic: max count is T = 30, which fits in CW bits.
- **DRAIN**
  - Presents `count_valid = 1`, `count_out = cnt[idx]`, `count_idx = idx`.
  - A transfer happens when `count_valid && count_ready`; each transfer does `idx <= idx + 1`.
  - The transfer with idx == CH-1 moves the FSM to `FIN`.
  - `count_out`/`count_idx` stay stable while `count_ready` is low.
- **FIN**
  - Lasts one cycle: `done = 1`, all counters and step cleared, `idx = 0`.
  - Next state is `ACCUM`.
- `data_in_valid` in `DRAIN` or `FIN`: the beat is dropped, counters are unchanged, and `overrun <= 1`.
- `overrun` is cleared only by `rst_n` or `clear`.
- `clear`: from any state, the next state is `ACCUM` with counters, step, idx and `overrun` zeroed, `count_valid = 0`, and no `done` pulse. A beat arriving in the same cycle as `clear` is discarded.
- The ROM `block_sel` is not used by this block; frames are purely positional.

## Timing
- Reset values: `count_out = 0`, `count_idx = 0`, `count_valid = 0`, `overrun = 0`, `done = 0`.
- All outputs are registered or decoded from registered state; there is no combinational path from any input to any output.
- An accepted beat updates the counters at the same clock edge.
- After the T-th beat edge, `count_valid` rises in the next cycle.
- With `count_ready` held high, the drain takes exactly CH cycles, and `done` is high in the cycle after the last transfer.
- Minimum frame cost: T accumulation cycles + CH drain cycles + 1 `FIN` cycle. A beat arriving the cycle after `FIN` is counted into the new frame.
- `rst_n` asserted mid-frame takes effect immediately and asynchronously; partial counts are lost.

## Configuration
- `SPIKE_RATE_ARGMAX_EN` defined:
  - Adds outputs `argmax_idx` (IW) and `argmax_cnt` (CW), reset to 0.
  - Argmax is a running compare over the counts as they transfer in `DRAIN`. Ties keep the lower index.
  - `argmax_idx`/`argmax_cnt` are valid and held from the `done` pulse until the next frame's `FIN` or `clear`.
  - `clear` zeroes both outputs.
- Not defined: these ports and the compare logic are absent; all other behaviour is identical.

## Test plan
- 30 beats of `data_in = 16'hFFFF`, `count_ready = 1` -> counts 30 for idx 0..15 on consecutive cycles; `done` pulses once; `overrun = 0`.
- 30 beats alternating `16'hAAAA`/`16'h5555` -> every channel counts 15; drain order is idx 0..15.
- `count_ready` toggled 1,0,0,1,... during drain -> no count is lost or duplicated; `count_out`/`count_idx` hold while stalled; `done` comes only after 16 transfers.
- Beat with `data_in_valid` during `DRAIN` -> `overrun = 1`, counts unchanged; `overrun` stays 1 through `done`; `clear` returns it to 0.
- `clear` after 12 beats, then 30 beats of `16'h0001` -> ch0 = 30, all other channels 0; async `rst_n` mid-drain -> all outputs 0 immediately.
- With `SPIKE_RATE_ARGMAX_EN`: ch3 and ch9 each spike 20 times, all others fewer -> `argmax_idx = 3`, `argmax_cnt = 20` at `done`.
